// File: rtl/fetch_unit.sv
// Instruction fetch: owns fetch PC, reads imem, queues words for decode in a 2-entry FIFO.
// Latency: request in n, 1-cycle imem response in n+1, instr_valid in n+2 (registered FIFO head).
// Backpressure: requests are credit-limited to 2 outstanding+buffered; decode_ready low stalls the head.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              ADDR_WIDTH = 9,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [XLEN-1:0]       imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  instr_valid,
    input  logic                  decode_ready,
    output logic [XLEN-1:0]       instr,
    output logic [XLEN-1:0]       instr_pc,
    output logic [XLEN-1:0]       pc_plus4
);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] buf_instr [2];
    logic [XLEN-1:0] buf_pc    [2];
    logic            rd_ptr;
    logic [1:0]      buf_cnt;
    logic [XLEN-1:0] pcq [2];
    logic            pcq_head;
    logic [1:0]      live_cnt;
    logic [2:0]      drop_cnt;

    logic       pop;
    logic [2:0] occ;
    logic       req_fire;
    logic       rsp_drop;
    logic       push;
    logic       buf_nonempty;
    logic       unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign buf_nonempty   = (buf_cnt != 2'd0);
    assign instr_valid    = buf_nonempty & ~redirect_valid;
    assign pop            = instr_valid & decode_ready;
    assign occ            = {1'b0, live_cnt} + {1'b0, buf_cnt} - {2'b00, pop};
    assign imem_req_valid = ~rst & ~redirect_valid & (occ < 3'd2);
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign imem_addr      = fetch_pc[ADDR_WIDTH+1:2];

    // Responses owed to pre-redirect requests are swallowed before any live one.
    assign rsp_drop = imem_rsp_valid & (drop_cnt != 3'd0);
    assign push     = imem_rsp_valid & (drop_cnt == 3'd0) & ~redirect_valid;

    assign instr    = buf_nonempty ? buf_instr[rd_ptr] : '0;
    assign instr_pc = buf_nonempty ? buf_pc[rd_ptr] : '0;
    assign pc_plus4 = buf_nonempty ? buf_pc[rd_ptr] + XLEN'(4) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= 1'b0;
            buf_cnt  <= 2'd0;
            pcq_head <= 1'b0;
            live_cnt <= 2'd0;
            drop_cnt <= 3'd0;
            for (int i = 0; i < 2; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
                pcq[i]       <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            buf_cnt  <= 2'd0;
            live_cnt <= 2'd0;
            // Every outstanding request becomes stale; a response this cycle retires one of them.
            drop_cnt <= drop_cnt + {1'b0, live_cnt} - {2'b00, imem_rsp_valid};
        end else begin
            if (req_fire) begin
                fetch_pc                        <= fetch_pc + XLEN'(4);
                pcq[pcq_head + live_cnt[0]]     <= fetch_pc;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 3'd1;
            end
            if (push) begin
                buf_instr[rd_ptr + buf_cnt[0]] <= imem_rsp_data;
                buf_pc[rd_ptr + buf_cnt[0]]    <= pcq[pcq_head];
                pcq_head                       <= ~pcq_head;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            live_cnt <= live_cnt + {1'b0, req_fire} - {1'b0, push};
            buf_cnt  <= buf_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order imem model with programmable latency, scoreboard of expected fetches.
// Per-cycle vector tables for exact timing, hand sequences for redirect, stall, wrap and async reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [8:0]  imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        decode_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .decode_ready   (decode_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus4       (pc_plus4)
    );

    typedef struct {
        int         due;
        logic [8:0] addr;
        bit         stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    typedef struct {
        bit          rst_before;
        int          lat;
        bit          drdy;
        bit          mrdy;
        bit          redir;
        logic [31:0] rpc;
        bit          exp_vld;
        logic [31:0] exp_pc;
        bit          exp_req;
    } vec_t;

    mreq_t mq[$];
    sb_t   sb[$];
    vec_t  tbl[$];

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] exp_pc   = '0;
    logic [31:0] req_pc   = '0;
    bit          popped;
    logic [31:0] popped_pc;
    logic        s_vld;
    logic        s_req;
    logic [31:0] s_pc;

    function automatic logic [31:0] memword(input logic [8:0] a);
        return {7'h55, a, 7'h2A, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_vec(input bit rb, input int l, input bit d, input bit m, input bit r,
                           input logic [31:0] rpc, input bit ev, input logic [31:0] ep, input bit eq);
        vec_t v;
        v = '{rb, l, d, m, r, rpc, ev, ep, eq};
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        decode_ready   = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mq.delete();
        sb.delete();
        exp_pc = '0;
        req_pc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // One clock cycle: drive at the falling edge, sample 1ns later, update the models.
    task automatic step(input bit drdy, input bit mrdy, input bit redir, input logic [31:0] rpc);
        mreq_t m;
        sb_t   e;
        bit    have_rsp;
        m = '{0, 9'd0, 1'b1};
        decode_ready   = drdy;
        imem_req_ready = mrdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        have_rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        if (have_rsp) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(m.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        s_vld  = instr_valid;
        s_req  = imem_req_valid;
        s_pc   = instr_pc;
        popped = 1'b0;
        if (redir) begin
            chk("redir_instr_valid", 32'(instr_valid), 32'd0);
            chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
        end
        if (instr_valid && drdy) begin
            popped    = 1'b1;
            popped_pc = instr_pc;
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL pop_empty: got pc %h expected no instruction (cycle %0d)", instr_pc, cyc);
            end else begin
                e = sb.pop_front();
                chk("instr_pc", instr_pc, e.pc);
                chk("instr", instr, e.instr);
                chk("pc_plus4", pc_plus4, e.pc + 32'd4);
            end
        end
        if (have_rsp && !m.stale && !redir) begin
            chk("fifo_room", 32'(sb.size() < 2), 32'd1);
            e.pc    = exp_pc;
            e.instr = memword(exp_pc[10:2]);
            sb.push_back(e);
            exp_pc = exp_pc + 32'd4;
        end
        if (imem_req_valid) chk("imem_addr", 32'(imem_addr), 32'(req_pc[10:2]));
        if (imem_req_valid && mrdy) begin
            m = '{cyc + lat, imem_addr, 1'b0};
            mq.push_back(m);
            req_pc = req_pc + 32'd4;
        end
        if (redir) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            sb.delete();
            exp_pc = {rpc[31:2], 2'b00};
            req_pc = exp_pc;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_pop(input string name, input logic [31:0] exp);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (popped) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: got no instruction within 20 cycles, expected pc %h", name, exp);
        end else begin
            chk(name, popped_pc, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        decode_ready   = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // Straight-line fetch, then a redirect that collides with a response and a pop.
        add_vec(1, 1, 1, 1, 0, 32'h0,   0, 32'h0,   1);
        add_vec(0, 1, 1, 1, 0, 32'h0,   0, 32'h0,   1);
        add_vec(0, 1, 1, 1, 0, 32'h0,   1, 32'h0,   1);
        add_vec(0, 1, 1, 1, 0, 32'h0,   1, 32'h4,   1);
        add_vec(0, 1, 1, 1, 0, 32'h0,   1, 32'h8,   1);
        add_vec(0, 1, 1, 1, 0, 32'h0,   1, 32'hC,   1);
        add_vec(0, 1, 1, 1, 1, 32'h103, 0, 32'h0,   0);
        add_vec(0, 1, 1, 1, 0, 32'h0,   0, 32'h0,   1);
        add_vec(0, 1, 1, 1, 0, 32'h0,   0, 32'h0,   1);
        add_vec(0, 1, 1, 1, 0, 32'h0,   1, 32'h100, 1);
        add_vec(0, 1, 1, 1, 0, 32'h0,   1, 32'h104, 1);
        // Decode stall for 5 cycles from the first valid instruction.
        add_vec(1, 1, 1, 1, 0, 32'h0,   0, 32'h0,   1);
        add_vec(0, 1, 1, 1, 0, 32'h0,   0, 32'h0,   1);
        for (int i = 0; i < 5; i++)
            add_vec(0, 1, 0, 1, 0, 32'h0, 1, 32'h0, 0);
        add_vec(0, 1, 1, 1, 0, 32'h0,   1, 32'h0,   1);
        add_vec(0, 1, 1, 1, 0, 32'h0,   1, 32'h4,   1);
        add_vec(0, 1, 1, 1, 0, 32'h0,   1, 32'h8,   1);
        add_vec(0, 1, 1, 1, 0, 32'h0,   1, 32'hC,   1);

        #1 rst = 1'b1;
        #2;
        chk("reset_instr_valid", 32'(instr_valid), 32'd0);
        chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
        chk("reset_instr", instr, 32'd0);
        chk("reset_instr_pc", instr_pc, 32'd0);
        chk("reset_pc_plus4", pc_plus4, 32'd0);

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) begin
                lat = tbl[i].lat;
                do_reset();
            end
            step(tbl[i].drdy, tbl[i].mrdy, tbl[i].redir, tbl[i].rpc);
            chk($sformatf("tbl%0d_vld", i), 32'(s_vld), 32'(tbl[i].exp_vld));
            if (tbl[i].exp_vld) chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].exp_req));
        end

        // 3-cycle memory, two requests in flight when the redirect lands.
        lat = 3;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("lat3_second_req", 32'(s_req), 32'd1);
        step(1'b1, 1'b1, 1'b1, 32'h40);
        wait_pop("lat3_first_after_redirect", 32'h40);
        wait_pop("lat3_second_after_redirect", 32'h44);

        // Memory not ready for 4 cycles, then word-address wrap at the top of memory.
        lat = 1;
        do_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            chk("mem_stall_req_held", 32'(s_req), 32'd1);
        end
        wait_pop("mem_stall_resume", 32'hC);
        wait_pop("mem_stall_next", 32'h10);
        step(1'b1, 1'b1, 1'b1, 32'h7FC);
        wait_pop("wrap_top", 32'h7FC);
        wait_pop("wrap_over", 32'h800);

        // Asynchronous reset with both FIFO entries occupied.
        do_reset();
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("arst_pre_vld", 32'(instr_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_instr_valid", 32'(instr_valid), 32'd0);
        chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("arst_instr_pc", instr_pc, 32'd0);
        do_reset();
        wait_pop("arst_restart0", 32'h0);
        wait_pop("arst_restart1", 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
